// File: rtl/spi_xfer_sched.sv
// -----------------------------------------------------------------------------
// spi_xfer_sched
//
// Purpose:
//   Schedules SPI transfers from two requesters onto a single SPI top.
//   An idle scheduler grants one requester (round-robin), latches its
//   master/slave configuration and tx bytes, and lets the configuration
//   settle for CFG_SETTLE cycles. It then pulses trans_en and waits for
//   the SPI top interrupt, or for a timeout. Finally it returns a one-cycle
//   completion pulse to the owning requester.
//
// Parameters:
//   CFG_SETTLE  cycles the configuration is held before trans_en (1..15)
//   TIMEOUT     max WAIT cycles before the transfer is aborted (2..65535)
//
// Ports:
//   clk, rst             clock (rising edge) and synchronous active-high reset
//   req_vld[1:0]         per-requester transfer request
//   req_rdy[1:0]         one-hot accept pulse (same cycle as the grant)
//   req_cfg_m/s[63:0]    master/slave config, requester i at [32i+31:32i]
//   req_data_m/s[15:0]   master/slave tx byte, requester i at [8i+7:8i]
//   rsp_vld[1:0]         one-hot completion pulse to the owner
//   rsp_data_m/s[7:0]    rx bytes captured from the SPI top on interrupt
//   rsp_err              timeout flag, valid with rsp_vld
//   busy                 high whenever the scheduler is not idle
//   data_config_master/slave, i_data_m/s, trans_en   drive the SPI top
//   interupt_request, o_data_m/s                     returned by the SPI top
// -----------------------------------------------------------------------------
module spi_xfer_sched #(
  parameter int CFG_SETTLE = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_vld,
  output logic [1:0]  req_rdy,
  input  logic [63:0] req_cfg_m,
  input  logic [63:0] req_cfg_s,
  input  logic [15:0] req_data_m,
  input  logic [15:0] req_data_s,
  output logic [1:0]  rsp_vld,
  output logic [7:0]  rsp_data_m,
  output logic [7:0]  rsp_data_s,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] data_config_master,
  output logic [31:0] data_config_slave,
  output logic [7:0]  i_data_m,
  output logic [7:0]  i_data_s,
  output logic        trans_en,
  input  logic        interupt_request,
  input  logic [7:0]  o_data_m,
  input  logic [7:0]  o_data_s
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0]  SETTLE_LAST  = 4'(CFG_SETTLE - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_owner;      // requester owning the transfer in flight
  logic        r_last;       // requester granted most recently
  logic        r_done_once;  // a transfer has completed since reset
  logic [3:0]  r_settle_cnt;
  logic [15:0] r_to_cnt;
  logic [31:0] r_cfg_m;
  logic [31:0] r_cfg_s;
  logic [7:0]  r_data_m;
  logic [7:0]  r_data_s;
  logic [7:0]  r_rsp_m;
  logic [7:0]  r_rsp_s;
  logic        r_err;

  // Per-requester views of the packed operand buses.
  logic [31:0] w_cfg_m  [2];
  logic [31:0] w_cfg_s  [2];
  logic [7:0]  w_data_m [2];
  logic [7:0]  w_data_s [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign w_cfg_m[gi]  = req_cfg_m[32*gi +: 32];
      assign w_cfg_s[gi]  = req_cfg_s[32*gi +: 32];
      assign w_data_m[gi] = req_data_m[8*gi +: 8];
      assign w_data_s[gi] = req_data_s[8*gi +: 8];
    end
  endgenerate

  logic w_any_req;
  logic w_gidx;
  logic w_same_cfg;
  logic w_load;
  logic w_capture;
  logic w_timeout;
  logic w_done;

  // Round-robin pick: with both requesting, take the one not granted last.
  // r_last resets to 1 so requester 0 wins the first contested grant.
  always_comb begin
    w_any_req = |req_vld;
    if (req_vld == 2'b11) begin
      w_gidx = ~r_last;
    end else begin
      w_gidx = req_vld[1];
    end
    // The settle time is only skipped when the SPI top already holds the
    // exact configuration from a finished transfer.
    w_same_cfg = r_done_once &&
                 (w_cfg_m[w_gidx] == r_cfg_m) &&
                 (w_cfg_s[w_gidx] == r_cfg_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_rdy      = 2'b00;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        // The grant is gated by rst so no accept pulse is seen while the
        // block is held in reset.
        if (w_any_req && !rst) begin
          req_rdy      = w_gidx ? 2'b10 : 2'b01;
          w_load       = 1'b1;
          w_state_next = w_same_cfg ? START : CFG;
        end
      end
      CFG: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_next = START;
        end
      end
      START: begin
        w_state_next = WAIT;
      end
      WAIT: begin
        // An interrupt on the final counted cycle still wins over timeout.
        if (interupt_request) begin
          w_capture    = 1'b1;
          w_state_next = DONE;
        end else if (r_to_cnt == TIMEOUT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_done_once  <= 1'b0;
      r_settle_cnt <= 4'd0;
      r_to_cnt     <= 16'd0;
      r_cfg_m      <= 32'd0;
      r_cfg_s      <= 32'd0;
      r_data_m     <= 8'd0;
      r_data_s     <= 8'd0;
      r_rsp_m      <= 8'd0;
      r_rsp_s      <= 8'd0;
      r_err        <= 1'b0;
    end else begin
      if (w_load) begin
        r_owner  <= w_gidx;
        r_cfg_m  <= w_cfg_m[w_gidx];
        r_cfg_s  <= w_cfg_s[w_gidx];
        r_data_m <= w_data_m[w_gidx];
        r_data_s <= w_data_s[w_gidx];
      end

      if (w_load) begin
        r_settle_cnt <= 4'd0;
      end else if (r_state == CFG) begin
        r_settle_cnt <= r_settle_cnt + 4'd1;
      end

      // WAIT always exits at TIMEOUT_LAST, so the counter never wraps.
      if (r_state == START) begin
        r_to_cnt <= 16'd0;
      end else if (r_state == WAIT) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end

      if (w_capture) begin
        r_rsp_m <= o_data_m;
        r_rsp_s <= o_data_s;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end

      if (w_done) begin
        r_last      <= r_owner;
        r_done_once <= 1'b1;
      end
    end
  end

  assign trans_en           = (r_state == START);
  assign busy               = (r_state != IDLE);
  assign rsp_vld            = (r_state == DONE) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err            = r_err;
  assign rsp_data_m         = r_rsp_m;
  assign rsp_data_s         = r_rsp_s;
  assign data_config_master = r_cfg_m;
  assign data_config_slave  = r_cfg_s;
  assign i_data_m           = r_data_m;
  assign i_data_s           = r_data_s;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_sched
//
// Directed bench for spi_xfer_sched. The main instance uses default
// parameters. A second instance with TIMEOUT=8 exercises the abort path.
// Inputs are driven 2 time units after the rising edge. Main-instance
// events are logged by a monitor on the falling edge with cycle stamps.
// -----------------------------------------------------------------------------
module tb_spi_xfer_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_vld;
  logic [63:0] req_cfg_m;
  logic [63:0] req_cfg_s;
  logic [15:0] req_data_m;
  logic [15:0] req_data_s;
  logic        irq;
  logic [7:0]  o_dm;
  logic [7:0]  o_ds;

  logic [1:0]  req_rdy;
  logic [1:0]  rsp_vld;
  logic [7:0]  rsp_data_m;
  logic [7:0]  rsp_data_s;
  logic        rsp_err;
  logic        busy;
  logic [31:0] dcm;
  logic [31:0] dcs;
  logic [7:0]  idm;
  logic [7:0]  ids;
  logic        trans_en;

  // Second instance (short timeout).
  logic [1:0]  t_req_vld;
  logic        t_irq;
  logic [1:0]  t_req_rdy;
  logic [1:0]  t_rsp_vld;
  logic [7:0]  t_rsp_data_m;
  logic [7:0]  t_rsp_data_s;
  logic        t_rsp_err;
  logic        t_busy;
  logic [31:0] t_dcm;
  logic [31:0] t_dcs;
  logic [7:0]  t_idm;
  logic [7:0]  t_ids;
  logic        t_trans_en;

  spi_xfer_sched u_dut (
    .clk                (clk),
    .rst                (rst),
    .req_vld            (req_vld),
    .req_rdy            (req_rdy),
    .req_cfg_m          (req_cfg_m),
    .req_cfg_s          (req_cfg_s),
    .req_data_m         (req_data_m),
    .req_data_s         (req_data_s),
    .rsp_vld            (rsp_vld),
    .rsp_data_m         (rsp_data_m),
    .rsp_data_s         (rsp_data_s),
    .rsp_err            (rsp_err),
    .busy               (busy),
    .data_config_master (dcm),
    .data_config_slave  (dcs),
    .i_data_m           (idm),
    .i_data_s           (ids),
    .trans_en           (trans_en),
    .interupt_request   (irq),
    .o_data_m           (o_dm),
    .o_data_s           (o_ds)
  );

  spi_xfer_sched #(.CFG_SETTLE(2), .TIMEOUT(8)) u_dut_to (
    .clk                (clk),
    .rst                (rst),
    .req_vld            (t_req_vld),
    .req_rdy            (t_req_rdy),
    .req_cfg_m          (req_cfg_m),
    .req_cfg_s          (req_cfg_s),
    .req_data_m         (req_data_m),
    .req_data_s         (req_data_s),
    .rsp_vld            (t_rsp_vld),
    .rsp_data_m         (t_rsp_data_m),
    .rsp_data_s         (t_rsp_data_s),
    .rsp_err            (t_rsp_err),
    .busy               (t_busy),
    .data_config_master (t_dcm),
    .data_config_slave  (t_dcs),
    .i_data_m           (t_idm),
    .i_data_s           (t_ids),
    .trans_en           (t_trans_en),
    .interupt_request   (t_irq),
    .o_data_m           (o_dm),
    .o_data_s           (o_ds)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Falling-edge event monitor for the main instance.
  int         cyc = 0;
  int         n_rdy = 0;
  int         n_te = 0;
  int         n_rsp = 0;
  int         rdy_cyc = 0;
  int         te_cyc = 0;
  int         rsp_cyc = 0;
  logic [1:0] rdy_val = 2'b00;
  logic [1:0] rsp_val = 2'b00;
  logic [7:0] rsp_dm = 8'h00;
  logic [7:0] rsp_ds = 8'h00;
  logic       rsp_e = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (|req_rdy) begin
      n_rdy   <= n_rdy + 1;
      rdy_cyc <= cyc + 1;
      rdy_val <= req_rdy;
    end
    if (trans_en) begin
      n_te   <= n_te + 1;
      te_cyc <= cyc + 1;
    end
    if (|rsp_vld) begin
      n_rsp   <= n_rsp + 1;
      rsp_cyc <= cyc + 1;
      rsp_val <= rsp_vld;
      rsp_dm  <= rsp_data_m;
      rsp_ds  <= rsp_data_s;
      rsp_e   <= rsp_err;
    end
  end

  int irq_cyc = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_rdy(input string tag);
    int  old;
    logic ok;
    old = n_rdy;
    ok  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (n_rdy != old) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, ok, 1'b1);
  endtask

  task automatic wait_te(input string tag);
    int  old;
    logic ok;
    old = n_te;
    ok  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (n_te != old) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, ok, 1'b1);
  endtask

  task automatic wait_rsp(input string tag);
    int  old;
    logic ok;
    old = n_rsp;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (n_rsp != old) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, ok, 1'b1);
  endtask

  task automatic pulse_irq(input logic [7:0] dm, input logic [7:0] ds);
    o_dm    = dm;
    o_ds    = ds;
    irq     = 1'b1;
    irq_cyc = cyc;
    step(1);
    irq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         old_rsp;
    int         steps;
    logic       ok;
    logic [1:0] exp_own [3];
    exp_own[0] = 2'b01;
    exp_own[1] = 2'b10;
    exp_own[2] = 2'b01;

    rst        = 1'b1;
    req_vld    = 2'b00;
    req_cfg_m  = 64'd0;
    req_cfg_s  = 64'd0;
    req_data_m = 16'd0;
    req_data_s = 16'd0;
    irq        = 1'b0;
    o_dm       = 8'd0;
    o_ds       = 8'd0;
    t_req_vld  = 2'b00;
    t_irq      = 1'b0;
    step(3);

    // Reset state
    check_eq("rst_req_rdy", req_rdy, 2'b00);
    check_eq("rst_rsp_vld", rsp_vld, 2'b00);
    check_eq("rst_trans_en", trans_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_cfg_m", dcm, 32'd0);
    check_eq("rst_data_m", idm, 8'd0);
    check_eq("rst_rsp_data_m", rsp_data_m, 8'd0);
    rst = 1'b0;
    step(1);

    // Single request 0, irq 20 cycles after trans_en
    req_cfg_m[31:0]  = 32'hD6108011;
    req_cfg_s[31:0]  = 32'h00001234;
    req_data_m[7:0]  = 8'hA5;
    req_data_s[7:0]  = 8'hC3;
    req_vld          = 2'b01;
    wait_rdy("t1_rdy_seen");
    req_vld = 2'b00;
    check_eq("t1_rdy_owner", rdy_val, 2'b01);
    check_eq("t1_cfg_m_out", dcm, 32'hD6108011);
    check_eq("t1_cfg_s_out", dcs, 32'h00001234);
    check_eq("t1_data_m_out", idm, 8'hA5);
    check_eq("t1_data_s_out", ids, 8'hC3);
    check_eq("t1_busy", busy, 1'b1);
    wait_te("t1_te_seen");
    check_eq("t1_te_latency", te_cyc - rdy_cyc, 3);
    step(20);
    pulse_irq(8'h3C, 8'h96);
    wait_rsp("t1_rsp_seen");
    check_eq("t1_rsp_owner", rsp_val, 2'b01);
    check_eq("t1_rsp_data_m", rsp_dm, 8'h3C);
    check_eq("t1_rsp_data_s", rsp_ds, 8'h96);
    check_eq("t1_rsp_err", rsp_e, 1'b0);
    check_eq("t1_rsp_latency", rsp_cyc - irq_cyc, 2);
    check_eq("t1_rdy_pulses", n_rdy, 1);
    check_eq("t1_te_pulses", n_te, 1);
    check_eq("t1_idle_busy", busy, 1'b0);
    check_eq("t1_idle_rsp_vld", rsp_vld, 2'b00);
    check_eq("t1_hold_cfg_m", dcm, 32'hD6108011);

    // irq during CFG is ignored (requester 1, new config)
    req_cfg_m[63:32] = 32'h11112222;
    req_cfg_s[63:32] = 32'h33334444;
    req_data_m[15:8] = 8'h11;
    req_data_s[15:8] = 8'h22;
    req_vld          = 2'b10;
    wait_rdy("t2_rdy_seen");
    req_vld = 2'b00;
    check_eq("t2_rdy_owner", rdy_val, 2'b10);
    pulse_irq(8'h77, 8'h88);
    wait_te("t2_te_seen");
    check_eq("t2_te_latency", te_cyc - rdy_cyc, 3);
    step(6);
    check_eq("t2_no_early_rsp", n_rsp, 1);
    check_eq("t2_still_busy", busy, 1'b1);
    pulse_irq(8'h81, 8'h18);
    wait_rsp("t2_rsp_seen");
    check_eq("t2_rsp_owner", rsp_val, 2'b10);
    check_eq("t2_rsp_data_m", rsp_dm, 8'h81);
    check_eq("t2_rsp_data_s", rsp_ds, 8'h18);
    check_eq("t2_rsp_err", rsp_e, 1'b0);

    // Identical config on requester 1 skips the settle time
    req_data_m[15:8] = 8'h99;
    req_vld          = 2'b10;
    wait_rdy("t3_rdy_seen");
    req_vld = 2'b00;
    check_eq("t3_data_m_out", idm, 8'h99);
    wait_te("t3_te_seen");
    check_eq("t3_te_latency", te_cyc - rdy_cyc, 1);
    step(2);
    pulse_irq(8'h55, 8'h66);
    wait_rsp("t3_rsp_seen");
    check_eq("t3_rsp_owner", rsp_val, 2'b10);
    check_eq("t3_rsp_data_m", rsp_dm, 8'h55);

    // Both requesting for three transfers: grants 0, 1, 0
    old_rsp = n_rsp;
    req_vld = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_rdy("t4_rdy_seen");
      check_eq("t4_grant_owner", rdy_val, exp_own[i]);
      check_eq("t4_data_m_out", idm, (exp_own[i] == 2'b01) ? 8'hA5 : 8'h99);
      wait_te("t4_te_seen");
      step(2);
      pulse_irq(8'hA0 + 8'(i), 8'hB0 + 8'(i));
      wait_rsp("t4_rsp_seen");
      check_eq("t4_rsp_owner", rsp_val, exp_own[i]);
      check_eq("t4_rsp_data_m", rsp_dm, 8'hA0 + 8'(i));
    end
    req_vld = 2'b00;
    check_eq("t4_rsp_count", n_rsp - old_rsp, 3);

    // Reset while waiting, then a stray irq, then a contested grant
    req_vld = 2'b01;
    wait_rdy("t5_rdy_seen");
    req_vld = 2'b00;
    wait_te("t5_te_seen");
    step(3);
    old_rsp = n_rsp;
    rst = 1'b1;
    step(1);
    check_eq("t5_rst_busy", busy, 1'b0);
    check_eq("t5_rst_trans_en", trans_en, 1'b0);
    check_eq("t5_rst_rsp_vld", rsp_vld, 2'b00);
    check_eq("t5_rst_rsp_err", rsp_err, 1'b0);
    check_eq("t5_rst_cfg_m", dcm, 32'd0);
    check_eq("t5_rst_cfg_s", dcs, 32'd0);
    check_eq("t5_rst_data_m", idm, 8'd0);
    check_eq("t5_rst_rsp_data_m", rsp_data_m, 8'd0);
    step(1);
    rst = 1'b0;
    pulse_irq(8'hEE, 8'hEE);
    step(5);
    check_eq("t5_no_rsp", n_rsp, old_rsp);
    check_eq("t5_idle_busy", busy, 1'b0);
    req_vld = 2'b11;
    wait_rdy("t5_rdy2_seen");
    req_vld = 2'b00;
    check_eq("t5_grant_owner", rdy_val, 2'b01);
    wait_te("t5_te2_seen");
    check_eq("t5_te_latency", te_cyc - rdy_cyc, 3);
    pulse_irq(8'h42, 8'h24);
    wait_rsp("t5_rsp_seen");
    check_eq("t5_rsp_owner", rsp_val, 2'b01);
    check_eq("t5_rsp_data_m", rsp_dm, 8'h42);

    // TIMEOUT=8 instance: one normal transfer, then a timed-out one
    t_req_vld = 2'b01;
    #1;
    check_eq("t6_rdy", t_req_rdy, 2'b01);
    step(1);
    t_req_vld = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (t_trans_en) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check_eq("t6_te_seen", ok, 1'b1);
    o_dm  = 8'h5A;
    o_ds  = 8'hA5;
    t_irq = 1'b1;
    step(2);
    t_irq = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (|t_rsp_vld) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check_eq("t6_rsp_seen", ok, 1'b1);
    check_eq("t6_rsp_data_m", t_rsp_data_m, 8'h5A);
    check_eq("t6_rsp_err", t_rsp_err, 1'b0);
    step(1);

    t_req_vld = 2'b01;
    step(1);
    t_req_vld = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (t_trans_en) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check_eq("t7_te_seen", ok, 1'b1);
    steps = 0;
    ok    = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      steps++;
      if (|t_rsp_vld) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("t7_rsp_seen", ok, 1'b1);
    check_eq("t7_wait_cycles", steps - 1, 8);
    check_eq("t7_rsp_owner", t_rsp_vld, 2'b01);
    check_eq("t7_rsp_err", t_rsp_err, 1'b1);
    check_eq("t7_rsp_data_m_kept", t_rsp_data_m, 8'h5A);
    check_eq("t7_rsp_data_s_kept", t_rsp_data_s, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
